add_avg: RTL

Block-averaging stage downstream of the `add` sum stage. Consumes the signed sum stream (`C`, 23 bits) under a valid/ready handshake, accumulates `ACC_LEN` consecutive samples, then rounds and saturates the block mean to `OUT_W` bits. Presents the result on a held valid/ready output. Accumulation of the next block overlaps with the wait on the output.

---
 rtl/add_avg.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/add_avg.sv
// add_avg: block-averaging stage for the signed sum stream of the add stage.
// Accumulates ACC_LEN consecutive samples, then rounds half-up and saturates
// the block mean to OUT_W bits. The result sits on a held valid/ready output
// while the next block is already accumulating; only the final sample of that
// next block is stalled until the pending result has been taken.
module add_avg #(
    parameter int IN_W    = 23,
    parameter int OUT_W   = 16,
    parameter int ACC_LEN = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_sat
);

    localparam int K     = $clog2(ACC_LEN);
    localparam int ACC_W = IN_W + K;          // ACC_LEN samples can never overflow this
    localparam int RW    = ACC_W + 1;         // headroom for the rounding bias
    localparam int CNT_W = (K > 0) ? K : 1;   // ACC_LEN = 1 still needs a one-bit counter

    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(ACC_LEN - 1);
    localparam logic signed [RW-1:0] RND_BIAS = RW'((2 ** K) / 2);   // 0 when K = 0
    localparam logic signed [RW-1:0] SAT_MAX  = RW'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [RW-1:0] SAT_MIN  = RW'(-(2 ** (OUT_W - 1)));

    typedef enum logic [1:0] {
        S_ACC = 2'd0,
        S_RND = 2'd1,
        S_OUT = 2'd2
    } state_t;

    state_t                   state_q;
    logic [CNT_W-1:0]         cnt_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  sum_q;
    logic                     out_valid_q;
    logic signed [OUT_W-1:0]  out_data_q;
    logic                     out_sat_q;

    logic                     in_ready_d;
    logic                     accept_d;
    logic                     last_d;
    logic signed [ACC_W-1:0]  acc_sum_d;
    logic signed [RW-1:0]     rnd_sum_d;
    logic signed [RW-1:0]     rnd_d;
    logic                     sat_hi_d;
    logic                     sat_lo_d;

    // Input acceptance: open while accumulating; while a result waits, stall only
    // the block's final sample unless the result is being taken this cycle.
    always_comb begin
        in_ready_d = 1'b0;
        case (state_q)
            S_ACC:   in_ready_d = 1'b1;
            S_OUT:   in_ready_d = (cnt_q != CNT_LAST) || out_ready;
            default: in_ready_d = 1'b0;
        endcase
        if (clr) begin
            in_ready_d = 1'b0;
        end
    end

    // Accumulate/round/saturate datapath shared by the FSM below.
    always_comb begin
        accept_d  = in_valid && in_ready_d;
        last_d    = accept_d && (cnt_q == CNT_LAST);
        acc_sum_d = acc_q + ACC_W'(in_data);
        rnd_sum_d = RW'(sum_q) + RND_BIAS;
        rnd_d     = rnd_sum_d >>> K;
        sat_hi_d  = (rnd_d > SAT_MAX);
        sat_lo_d  = (rnd_d < SAT_MIN);
    end

    assign in_ready  = in_ready_d;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

    // Block accumulator, result formatting and output handshake FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_ACC;
            cnt_q       <= '0;
            acc_q       <= '0;
            sum_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else if (clr) begin
            state_q     <= S_ACC;
            cnt_q       <= '0;
            acc_q       <= '0;
            sum_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            if (accept_d) begin
                if (last_d) begin
                    sum_q <= acc_sum_d;
                    acc_q <= '0;
                    cnt_q <= '0;
                end else begin
                    acc_q <= acc_sum_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end

            case (state_q)
                S_ACC: begin
                    if (last_d) begin
                        state_q <= S_RND;
                    end
                end
                S_RND: begin
                    out_valid_q <= 1'b1;
                    out_sat_q   <= sat_hi_d || sat_lo_d;
                    if (sat_hi_d) begin
                        out_data_q <= SAT_MAX[OUT_W-1:0];
                    end else if (sat_lo_d) begin
                        out_data_q <= SAT_MIN[OUT_W-1:0];
                    end else begin
                        out_data_q <= rnd_d[OUT_W-1:0];
                    end
                    state_q <= S_OUT;
                end
                S_OUT: begin
                    // A stalled final sample can only complete alongside a transfer.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= last_d ? S_RND : S_ACC;
                    end
                end
                default: begin
                    state_q <= S_ACC;
                end
            endcase
        end
    end

endmodule
